// File: rtl/cdc_pkg.sv
// Shared constants and types for the clock-domain-crossing blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cdc_pkg;

    // Default depth of every synchronizer chain in the cdc blocks.
    localparam int SYNC_STAGES_DEF = 2;

    // Type used for channel-count parameters of multi-channel cdc blocks.
    typedef int ch_cnt_t;

endpackage

// File: rtl/cdc_sync.sv
// N-flop level synchronizer cell for a single-bit signal.
// Latency: STAGES destination clock edges.
// Backpressure: none; the input is sampled every clock.
module cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_pulse_mc_chan.sv
// One lossless pulse-crossing channel: toggle request clka->clkb, toggle ack clkb->clka.
// Latency: launch one clka edge after the event, outb SYNC_STAGES+1 clkb edges after launch.
// Backpressure: events queue in a pending count (macro SYNC_PULSE_MC_CNT_EN) or a
//               1-bit pending flag (default); events beyond capacity are dropped and flagged on ovfa.
module sync_pulse_mc_chan
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 3
) (
    input  logic clka,
    input  logic rsta,
    input  logic clkb,
    input  logic rstb,
    input  logic ina,
    output logic busya,
    output logic ovfa,
    output logic outb
);

`ifdef SYNC_PULSE_MC_CNT_EN
    localparam int PW = CNT_W;
`else
    // Pending state is a single flag here; CNT_W has no effect on the width.
    localparam int PW = CNT_W - CNT_W + 1;
`endif

    localparam logic [PW-1:0] PMAX = '1;
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_nxt;
    logic          req;
    logic          ack_sync;
    logic          idle;
    logic          at_max;
    logic          cnt_nz;
    logic          inc;
    logic          dec;
    logic          req_s;
    logic          ackb;

    assign idle   = (req == ack_sync);
    assign at_max = (cnt == PMAX);
    assign cnt_nz = (cnt != '0);
    assign dec    = idle && cnt_nz;

`ifdef SYNC_PULSE_MC_CNT_EN
    // A launch frees a slot on the same edge, so a full counter still absorbs an event then.
    assign inc  = ina && (!at_max || dec);
    assign ovfa = ina && at_max && !dec;
`else
    // While the flag is set any further event is dropped, even on the launch edge.
    assign inc  = ina && !at_max;
    assign ovfa = ina && at_max;
`endif

    assign busya = !idle || cnt_nz;

    // Pending count: up on an accepted event, down on a launch, unchanged when both.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec) begin
            cnt_nxt = cnt + ONE;
        end else if (dec && !inc) begin
            cnt_nxt = cnt - ONE;
        end
    end

    // Source-side state: pending count and request toggle (toggles on each launch).
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            cnt <= '0;
            req <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            req <= req ^ dec;
        end
    end

    cdc_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clkb),
        .rst_n (rstb),
        .d     (req),
        .q     (req_s)
    );

    // Destination side: echo the request as ack and pulse outb on every request change.
    always_ff @(posedge clkb or negedge rstb) begin
        if (!rstb) begin
            ackb <= 1'b0;
            outb <= 1'b0;
        end else begin
            ackb <= req_s;
            outb <= req_s ^ ackb;
        end
    end

    cdc_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clka),
        .rst_n (rsta),
        .d     (ackb),
        .q     (ack_sync)
    );

endmodule

// File: rtl/sync_pulse_mc.sv
// Multi-channel lossless pulse synchronizer clka -> clkb (SYNC_PULSE_MC_CNT_EN selects pending counter).
// Latency: about SYNC_STAGES+1 clkb edges after launch; one round trip per delivered event.
// Backpressure: per-channel pending storage; overflow drops the event and pulses ovfa.
module sync_pulse_mc
    import cdc_pkg::*;
#(
    parameter ch_cnt_t CH          = 4,
    parameter int      SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int      CNT_W       = 3
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          clkb,
    input  logic          rstb,
    input  logic [CH-1:0] ina,
    output logic [CH-1:0] busya,
    output logic [CH-1:0] ovfa,
    output logic [CH-1:0] outb
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        sync_pulse_mc_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clka  (clka),
            .rsta  (rsta),
            .clkb  (clkb),
            .rstb  (rstb),
            .ina   (ina[i]),
            .busya (busya[i]),
            .ovfa  (ovfa[i]),
            .outb  (outb[i])
        );
    end

endmodule
